// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM encoding, command bytes,
// default timing and the host frame layout.
package ps2_pkg;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_INHIBIT   = 3'd1;
  localparam logic [2:0] S_REQ       = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_ACK       = 3'd4;
  localparam logic [2:0] S_WAIT_IDLE = 3'd5;

  localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] PS2_ACK_BYTE    = 8'hFA;

  localparam int unsigned PS2_CLK_HZ       = 50_000_000;
  localparam int unsigned PS2_INHIBIT_CYC  = 6000;
  localparam int unsigned PS2_START_TO_CYC = 750000;
  localparam int unsigned PS2_XFER_TO_CYC  = 100000;

  // Shifted out LSB first: data[0] .. data[7], then parity.
  typedef struct packed {
    logic       parity;
    logic [7:0] data;
  } ps2_frame_t;

  function automatic logic odd_parity(
    input logic [7:0] d
  );
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte request / status handshake between a command
// source (master) and the PS/2 host transmitter (slave).
interface ps2_host_tx_if;

  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_data,
    output tx_start,
    input  tx_busy,
    input  tx_done,
    input  tx_error
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output tx_busy,
    output tx_done,
    output tx_error
  );

endinterface

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for a PS/2 line plus a
// falling-edge pulse taken one cycle after the second flop.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic level,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // Idle bus level is high; reset there to avoid a false edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= line_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign fall  = s3 & ~s2;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send,
// clock out 8 data bits + odd parity, then wait for device ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ       = PS2_CLK_HZ,
  parameter int unsigned INHIBIT_CYC  = PS2_INHIBIT_CYC,
  parameter int unsigned START_TO_CYC = PS2_START_TO_CYC,
  parameter int unsigned XFER_TO_CYC  = PS2_XFER_TO_CYC
) (
  input  logic         CLOCK_50,
  input  logic         resetn,
  ps2_host_tx_if.slave tx,
  input  logic         ps2_clk_in,
  input  logic         ps2_dat_in,
  output logic         ps2_clk_oe,
  output logic         ps2_dat_oe,
  output logic         rx_inhibit
);

  localparam int unsigned TMR_MAX =
    (START_TO_CYC > XFER_TO_CYC) ?
    START_TO_CYC : XFER_TO_CYC;
  localparam int unsigned TMR_W =
    (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int unsigned ICNT_W =
    (INHIBIT_CYC > 1) ? $clog2(INHIBIT_CYC) : 1;

  localparam logic [TMR_W-1:0] START_LAST =
    TMR_W'(START_TO_CYC - 1);
  localparam logic [TMR_W-1:0] XFER_LAST =
    TMR_W'(XFER_TO_CYC - 1);
  localparam logic [ICNT_W-1:0] ICNT_LAST =
    ICNT_W'(INHIBIT_CYC - 1);

  if (CLK_HZ == 0 || INHIBIT_CYC == 0 ||
      START_TO_CYC == 0 || XFER_TO_CYC == 0)
  begin : g_bad_cfg
    $error("ps2_host_tx: timing parameters must be non-zero");
  end

  logic [2:0]        state;
  logic              clk_oe;
  logic              dat_oe;
  logic              done;
  logic              err;
  ps2_frame_t        sr;
  logic [3:0]        n;
  logic [ICNT_W-1:0] icnt;
  logic [TMR_W-1:0]  tmr;
  logic [TMR_W-1:0]  tmr_nxt;
  logic              tmo;

  logic clk_s;
  logic clk_fall;
  logic dat_s;
  logic dat_fall_unused;

  ps2_line_sync u_clk_sync (
    .clk     (CLOCK_50),
    .rst_n   (resetn),
    .line_in (ps2_clk_in),
    .level   (clk_s),
    .fall    (clk_fall)
  );

  ps2_line_sync u_dat_sync (
    .clk     (CLOCK_50),
    .rst_n   (resetn),
    .line_in (ps2_dat_in),
    .level   (dat_s),
    .fall    (dat_fall_unused)
  );

  assign tmr_nxt = (tmr == '1) ? tmr : tmr + 1'b1;

  // One timer: start window until edge 1, transfer window after.
  always_comb begin
    tmo = 1'b0;
    unique case (1'b1)
      (state == S_DATA) && (n == 4'd0):
        tmo = (tmr == START_LAST);
      (state == S_DATA) && (n != 4'd0),
      (state == S_ACK),
      (state == S_WAIT_IDLE):
        tmo = (tmr == XFER_LAST);
      default:
        tmo = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      clk_oe <= 1'b0;
      dat_oe <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      sr     <= '0;
      n      <= '0;
      icnt   <= '0;
      tmr    <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (tx.tx_start) begin
            sr.data   <= tx.tx_data;
            sr.parity <= odd_parity(tx.tx_data);
            icnt      <= '0;
            clk_oe    <= 1'b1;
            state     <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (icnt == ICNT_LAST) begin
            dat_oe <= 1'b1;
            state  <= S_REQ;
          end else begin
            icnt <= icnt + 1'b1;
          end
        end
        S_REQ: begin
          clk_oe <= 1'b0;
          n      <= '0;
          tmr    <= '0;
          state  <= S_DATA;
        end
        S_DATA: begin
          if (tmo) begin
            clk_oe <= 1'b0;
            dat_oe <= 1'b0;
            sr     <= '0;
            err    <= 1'b1;
            state  <= S_IDLE;
          end else if (clk_fall) begin
            n   <= n + 4'd1;
            tmr <= (n == 4'd0) ? '0 : tmr_nxt;
            // Edge 10 releases data so the device sees the stop bit.
            if (n == 4'd9) begin
              dat_oe <= 1'b0;
              state  <= S_ACK;
            end else begin
              dat_oe <= ~sr[0];
              sr     <= ps2_frame_t'({1'b0, sr[8:1]});
            end
          end else begin
            tmr <= tmr_nxt;
          end
        end
        S_ACK: begin
          if (tmo || (clk_fall && dat_s)) begin
            clk_oe <= 1'b0;
            dat_oe <= 1'b0;
            sr     <= '0;
            err    <= 1'b1;
            state  <= S_IDLE;
          end else begin
            tmr <= tmr_nxt;
            if (clk_fall) begin
              state <= S_WAIT_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          if (tmo) begin
            clk_oe <= 1'b0;
            dat_oe <= 1'b0;
            sr     <= '0;
            err    <= 1'b1;
            state  <= S_IDLE;
          end else if (clk_s && dat_s) begin
            done  <= 1'b1;
            state <= S_IDLE;
          end else begin
            tmr <= tmr_nxt;
          end
        end
        default: begin
          clk_oe <= 1'b0;
          dat_oe <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  assign ps2_clk_oe  = clk_oe;
  assign ps2_dat_oe  = dat_oe;
  assign tx.tx_busy  = (state != S_IDLE);
  assign tx.tx_done  = done;
  assign tx.tx_error = err;
  assign rx_inhibit  = (state != S_IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a behavioural PS/2
// device: device-generated clock, samples data while clock high.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH = 60;
  localparam int STO = 400;
  localparam int XTO = 1500;
  localparam int H   = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clk_oe;
  logic dat_oe;
  logic rx_inhibit;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic clk_line;
  logic dat_line;

  int n_chk = 0;
  int n_err = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  ps2_host_tx_if bus();

  always #10 clk = ~clk;

  assign clk_line = ~(clk_oe | dev_clk_low);
  assign dat_line = ~(dat_oe | dev_dat_low);

  ps2_host_tx #(
    .CLK_HZ       (50_000_000),
    .INHIBIT_CYC  (INH),
    .START_TO_CYC (STO),
    .XFER_TO_CYC  (XTO)
  ) dut (
    .CLOCK_50   (clk),
    .resetn     (rst_n),
    .tx         (bus),
    .ps2_clk_in (clk_line),
    .ps2_dat_in (dat_line),
    .ps2_clk_oe (clk_oe),
    .ps2_dat_oe (dat_oe),
    .rx_inhibit (rx_inhibit)
  );

  always @(posedge clk) begin
    #1;
    if (bus.tx_done) done_cnt++;
    if (bus.tx_error) err_cnt++;
    if (bus.tx_done && bus.tx_error) both_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h",
               tag, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    bus.tx_data  = b;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
  endtask

  // Counts cycles with clock pulled and data not yet pulled.
  task automatic wait_req(output int k);
    k = 0;
    for (int i = 0; i < INH + 20; i++) begin
      if (dat_oe) break;
      if (clk_oe) k++;
      @(negedge clk);
    end
  endtask

  task automatic dev_run(input string tg,
                         input int falls,
                         input bit ack,
                         input int poke,
                         output logic [10:0] got);
    bit ok;
    got = '0;
    ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!clk_oe && dat_oe) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tg, "_rts"}, 32'(ok), 1);
    got[0] = dat_line;
    repeat (10) @(negedge clk);
    for (int i = 1; i <= falls; i++) begin
      if (i == 11 && ack) begin
        dev_dat_low = 1'b1;
        repeat (5) @(negedge clk);
      end
      dev_clk_low = 1'b1;
      if (i == poke) begin
        bus.tx_data  = 8'hFF;
        bus.tx_start = 1'b1;
      end
      repeat (H) begin
        @(negedge clk);
        bus.tx_start = 1'b0;
      end
      if (i == falls && falls < 11) return;
      dev_clk_low = 1'b0;
      repeat (H) @(negedge clk);
      if (i <= 10) got[i] = dat_line;
    end
    dev_dat_low = 1'b0;
  endtask

  task automatic xfer(input string tg,
                      input logic [7:0] b,
                      input logic p,
                      input bit ack,
                      input int poke);
    logic [10:0] got;
    int k;
    int d0;
    int e0;
    d0 = done_cnt;
    e0 = err_cnt;
    send(b);
    wait_req(k);
    chk({tg, "_inhibit"}, k, INH);
    chk({tg, "_busy"}, 32'(bus.tx_busy), 1);
    chk({tg, "_rxinh"}, 32'(rx_inhibit), 1);
    dev_run(tg, 11, ack, poke, got);
    chk({tg, "_frame"}, 32'(got),
        32'({1'b1, p, b, 1'b0}));
    for (int i = 0; i < 200; i++) begin
      if (done_cnt != d0 || err_cnt != e0) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk({tg, "_done"}, done_cnt - d0, ack ? 1 : 0);
    chk({tg, "_error"}, err_cnt - e0, ack ? 0 : 1);
    chk({tg, "_idle"}, 32'(bus.tx_busy), 0);
    chk({tg, "_clk_rel"}, 32'(clk_oe), 0);
    chk({tg, "_dat_rel"}, 32'(dat_oe), 0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int k;
    int d0;
    logic [10:0] got;
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_clk_oe", 32'(clk_oe), 0);
    chk("rst_dat_oe", 32'(dat_oe), 0);
    chk("rst_busy", 32'(bus.tx_busy), 0);
    chk("rst_done", 32'(bus.tx_done), 0);
    chk("rst_error", 32'(bus.tx_error), 0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    xfer("t1_ed", 8'hED, 1'b1, 1'b1, 0);
    xfer("t2_07", 8'h07, 1'b0, 1'b1, 0);
    xfer("t2_00", 8'h00, 1'b1, 1'b1, 0);
    xfer("t3_noack", 8'hF4, 1'b0, 1'b0, 0);

    // Device silent after release: start timeout.
    d0 = done_cnt;
    send(8'hF4);
    wait_req(k);
    chk("t4_inhibit", k, INH);
    @(negedge clk);
    chk("t4_rel", 32'(clk_oe), 0);
    k = 0;
    for (int i = 0; i < STO + 50; i++) begin
      @(negedge clk);
      k++;
      if (bus.tx_error) break;
    end
    chk("t4_tmo_cyc", k, STO);
    chk("t4_clk_rel", 32'(clk_oe), 0);
    chk("t4_dat_rel", 32'(dat_oe), 0);
    chk("t4_no_done", done_cnt - d0, 0);
    repeat (5) @(negedge clk);

    xfer("t5_poke", 8'hED, 1'b1, 1'b1, 3);

    // Reset while the device holds clock low at edge 5.
    send(8'hED);
    wait_req(k);
    dev_run("t6", 5, 1'b0, 0, got);
    chk("t6_pre_dat", 32'(dat_oe), 1);
    @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_clk_oe", 32'(clk_oe), 0);
    chk("t6_dat_oe", 32'(dat_oe), 0);
    chk("t6_busy", 32'(bus.tx_busy), 0);
    chk("t6_rxinh", 32'(rx_inhibit), 0);
    chk("t6_done", 32'(bus.tx_done), 0);
    chk("t6_error", 32'(bus.tx_error), 0);
    dev_clk_low = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    xfer("t6_f4", 8'hF4, 1'b0, 1'b1, 0);

    chk("excl", both_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
